// File: rtl/register_file_pkg.sv
// -----------------------------------------------------------------------------
// register_file_pkg
//
// Shared constants and types for the datapath register file.
//
// Contents:
//   DATA_WIDTH - register / data-bus width
//   ADDR_WIDTH - register address width
//   NUM_REGS   - number of architectural registers (2**ADDR_WIDTH)
//   ZERO_REG   - address of the hard-wired zero register
//   word_t     - one register-wide data word
//   addr_t     - one register address
// -----------------------------------------------------------------------------
package register_file_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] ZERO_REG = 5'd0;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage : register_file_pkg

// File: rtl/register_file_register.sv
// -----------------------------------------------------------------------------
// register_file_register
//
// The `register` cell of the register file: one WIDTH-bit storage flop with an
// asynchronous active-low clear and a synchronous load enable.
//
// Ports:
//   clk_i    in   1      clock, loads on rising edge
//   rst_ni   in   1      asynchronous active-low clear
//   ld_en_i  in   1      load enable, sampled on rising edge
//   d_i      in   WIDTH  load data
//   q_o      out  WIDTH  stored value
// -----------------------------------------------------------------------------
module register_file_register
    import register_file_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ld_en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // NOTE: every always_comb output gets a default assignment first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        data_d = data_q;
        if (ld_en_i) begin
            data_d = d_i;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // its inputs before any of them change within the same edge. The storage is
    // small discrete flops, so clearing it in reset is cheap and required here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule : register_file_register

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//
// Three-port general-purpose register file: 2**ADDR_WIDTH registers of
// DATA_WIDTH bits, two combinational read ports and one clocked write port.
// Register 0 has no storage and always reads zero. There is no write-to-read
// bypass: a read of the register being written shows the old value until the
// write edge.
//
// Ports:
//   Clk    in   1           clock, writes on rising edge
//   Rst    in   1           asynchronous active-low reset, clears R1..R31
//   Adr1   in   ADDR_WIDTH  read address, port 1
//   Adr2   in   ADDR_WIDTH  read address, port 2
//   Awr    in   ADDR_WIDTH  write address
//   Din    in   DATA_WIDTH  write data
//   WrEn   in   1           write enable, active high
//   Dout1  out  DATA_WIDTH  contents of register Adr1
//   Dout2  out  DATA_WIDTH  contents of register Adr2
// -----------------------------------------------------------------------------
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = register_file_pkg::ADDR_WIDTH
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [ADDR_WIDTH-1:0] Adr1,
    input  logic [ADDR_WIDTH-1:0] Adr2,
    input  logic [ADDR_WIDTH-1:0] Awr,
    input  logic [DATA_WIDTH-1:0] Din,
    input  logic                  WrEn,
    output logic [DATA_WIDTH-1:0] Dout1,
    output logic [DATA_WIDTH-1:0] Dout2
);

    localparam int NUM_ENTRIES = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    // Register contents as seen by the read muxes; entry 0 is a constant.
    logic [DATA_WIDTH-1:0] reg_q [NUM_ENTRIES];

    // One load enable per stored register (R1 upward); R0 has no flop to load,
    // which is how writes to address 0 get discarded.
    logic [NUM_ENTRIES-1:1] load_en;

    // -------------------------------------------------------------------------
    // Write-address decoder
    // -------------------------------------------------------------------------
    always_comb begin
        load_en = '0;
        for (int i = 1; i < NUM_ENTRIES; i++) begin
            load_en[i] = WrEn && (Awr == ADDR_WIDTH'(i));
        end
    end

    // -------------------------------------------------------------------------
    // Storage: R1..R(N-1)
    // -------------------------------------------------------------------------
    assign reg_q[0] = '0;

    for (genvar g = 1; g < NUM_ENTRIES; g++) begin : g_reg
        register_file_register #(
            .WIDTH (DATA_WIDTH)
        ) u_reg (
            .clk_i   (Clk),
            .rst_ni  (Rst),
            .ld_en_i (load_en[g]),
            .d_i     (Din),
            .q_o     (reg_q[g])
        );
    end

    // -------------------------------------------------------------------------
    // Read multiplexers
    // -------------------------------------------------------------------------
    // The zero select is forced explicitly rather than relying on reg_q[0],
    // so the R0 behaviour stays visible at the mux itself.
    always_comb begin
        Dout1 = '0;
        if (Adr1 != ZERO_ADDR) begin
            Dout1 = reg_q[Adr1];
        end
    end

    always_comb begin
        Dout2 = '0;
        if (Adr2 != ZERO_ADDR) begin
            Dout2 = reg_q[Adr2];
        end
    end

endmodule : register_file

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
//
// Self-checking bench for register_file. A plain array of 32 words models the
// architectural register state; every read is checked against it.
// -----------------------------------------------------------------------------
module tb_register_file;

    logic        Clk;
    logic        Rst;
    logic [4:0]  Adr1;
    logic [4:0]  Adr2;
    logic [4:0]  Awr;
    logic [31:0] Din;
    logic        WrEn;
    logic [31:0] Dout1;
    logic [31:0] Dout2;

    int tests_run = 0;
    int tests_failed = 0;

    // Architectural model: index 0 is never written.
    logic [31:0] mdl [32];

    register_file dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Adr1  (Adr1),
        .Adr2  (Adr2),
        .Awr   (Awr),
        .Din   (Din),
        .WrEn  (WrEn),
        .Dout1 (Dout1),
        .Dout2 (Dout2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : mdl[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    endtask

    // Advance over one rising edge and apply the architectural write rule.
    task automatic tick();
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        we = WrEn;
        wa = Awr;
        wd = Din;
        @(posedge Clk);
        if (Rst && we && wa != 5'd0) mdl[wa] = wd;
        #1;
    endtask

    // One single-cycle write, driven from the falling edge.
    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge Clk);
        Awr  = a;
        Din  = d;
        WrEn = 1'b1;
        tick();
        @(negedge Clk);
        WrEn = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [4:0] a1, input logic [4:0] a2);
        Adr1 = a1;
        Adr2 = a2;
        #1;
        check({tag, "/dout1"}, Dout1, model_read(a1));
        check({tag, "/dout2"}, Dout2, model_read(a2));
    endtask

    initial begin
        model_clear();

        // ---------------- Reset overrides a write ----------------
        Rst  = 1'b0;
        WrEn = 1'b1;
        Awr  = 5'd3;
        Din  = 32'hDEAD_BEEF;
        Adr1 = 5'd3;
        Adr2 = 5'd31;
        repeat (2) @(posedge Clk);
        #1;
        check("reset/r3", Dout1, 32'h0);
        check("reset/r31", Dout2, 32'h0);
        @(negedge Clk);
        WrEn = 1'b0;
        Rst  = 1'b1;
        #1;
        check("post_release/r3", Dout1, 32'h0);
        check("post_release/r31", Dout2, 32'h0);

        // ---------------- Basic write / read ----------------
        write_reg(5'd1, 32'h0F0F_0F0F);
        write_reg(5'd2, 32'hFFFF_FFFF);
        Adr1 = 5'd1;
        Adr2 = 5'd2;
        #1;
        check("basic/r1", Dout1, 32'h0F0F_0F0F);
        check("basic/r2", Dout2, 32'hFFFF_FFFF);

        // ---------------- R0 and unwritten register ----------------
        write_reg(5'd0, 32'hF0F0_F0F0);
        Adr1 = 5'd0;
        Adr2 = 5'd3;
        #1;
        check("r0/read", Dout1, 32'h0);
        check("unwritten/r3", Dout2, 32'h0);

        // ---------------- WrEn gating ----------------
        @(negedge Clk);
        Din  = 32'h1234_5678;
        Awr  = 5'd1;
        WrEn = 1'b0;
        repeat (3) tick();
        Adr1 = 5'd1;
        #1;
        check("wren_gate/r1", Dout1, 32'h0F0F_0F0F);

        // ---------------- Same-address reads, no bypass ----------------
        @(negedge Clk);
        Adr1 = 5'd5;
        Adr2 = 5'd5;
        Awr  = 5'd5;
        Din  = 32'hA5A5_A5A5;
        WrEn = 1'b1;
        #1;
        check("r5_before/dout1", Dout1, 32'h0);
        check("r5_before/dout2", Dout2, 32'h0);
        tick();
        check("r5_after/dout1", Dout1, 32'hA5A5_A5A5);
        check("r5_after/dout2", Dout2, 32'hA5A5_A5A5);

        // Back-to-back writes to the neighbours
        @(negedge Clk);
        Awr = 5'd4;
        Din = 32'h4444_0004;
        tick();
        @(negedge Clk);
        Awr = 5'd6;
        Din = 32'h6666_0006;
        tick();
        @(negedge Clk);
        WrEn = 1'b0;
        #1;
        check("neighbours/r5_kept", Dout1, 32'hA5A5_A5A5);
        read_check("neighbours/r4_r6", 5'd4, 5'd6);
        check("neighbours/r4_value", Dout1, 32'h4444_0004);
        check("neighbours/r6_value", Dout2, 32'h6666_0006);

        // ---------------- Randomized traffic ----------------
        for (int n = 0; n < 300; n++) begin
            @(negedge Clk);
            WrEn = ($urandom_range(0, 3) != 0);
            Awr  = 5'($urandom_range(0, 31));
            Din  = $urandom;
            Adr1 = 5'($urandom_range(0, 31));
            Adr2 = (n % 4 == 0) ? Awr : 5'($urandom_range(0, 31));
            #1;
            check("rand/pre_edge/dout1", Dout1, model_read(Adr1));
            check("rand/pre_edge/dout2", Dout2, model_read(Adr2));
            tick();
            check("rand/post_edge/dout1", Dout1, model_read(Adr1));
            check("rand/post_edge/dout2", Dout2, model_read(Adr2));
        end
        @(negedge Clk);
        WrEn = 1'b0;

        // ---------------- Full sweep then async reset ----------------
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i));
        for (int i = 0; i < 32; i += 2) read_check("fill", 5'(i), 5'(31 - i));

        @(posedge Clk);
        #3;
        Rst  = 1'b0;
        model_clear();
        Adr1 = 5'd7;
        Adr2 = 5'd31;
        #1;
        check("async_rst/immediate/r7", Dout1, 32'h0);
        check("async_rst/immediate/r31", Dout2, 32'h0);
        for (int i = 0; i < 32; i++) read_check("async_rst/sweep", 5'(i), 5'(31 - i));

        @(negedge Clk);
        Rst = 1'b1;
        write_reg(5'd9, 32'h9999_9999);
        read_check("after_rst/r9", 5'd9, 5'd10);
        check("after_rst/r9_value", Dout1, 32'h9999_9999);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_register_file
